timer_ctrl_mc: RTL and testbench

- Multi-channel, parametrised control block for the timer subsystem. Sits between the APB register file (per-channel TDR/TCR images and write strobes) and the per-channel counter cores.
- Per channel it produces:
  - single-cycle load pulses and their start values (from a TDR write, a TCR LOAD rising edge, or hardware auto-reload on terminal count);
  - clock-select, direction and a gated count enable.
- A per-channel run-state FSM implements one-shot mode.

---
 rtl/timer_ctrl_mc_if.sv | 46 ++++
 rtl/timer_ctrl_mc.sv | 136 +++++++++++++
 tb/tb_timer_ctrl_mc.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/timer_ctrl_mc_if.sv
// -----------------------------------------------------------------------------
// timer_ctrl_mc_if
// Bundle between the APB register file / counter cores and the timer
// channel controller (timer_ctrl_mc).
//   master : register file + counter side (drives TDR/TCR, strobes, wrap
//            pulses; receives load/enable/select controls)
//   slave  : timer_ctrl_mc side
// Signals (channel i occupies slice i of each packed vector):
//   TDR_reg, TCR_reg     NUM_CH*DATA_WIDTH  reload data / control images
//   TDR_WR_pulse         NUM_CH             TDR write strobe
//   ovf_pulse, udf_pulse NUM_CH             counter wrap events
//   Cks                  2*NUM_CH           clock select
//   Load_Tdr             NUM_CH             one-cycle load strobe
//   count_start_value    NUM_CH*DATA_WIDTH  value to load
//   count_up_down        NUM_CH             1 = up, 0 = down
//   count_enable         NUM_CH             counter run enable
//   oneshot_done         NUM_CH             one-shot termination pulse
// -----------------------------------------------------------------------------
interface timer_ctrl_mc_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 4
);
    logic [NUM_CH*DATA_WIDTH-1:0] TDR_reg;
    logic [NUM_CH*DATA_WIDTH-1:0] TCR_reg;
    logic [NUM_CH-1:0]            TDR_WR_pulse;
    logic [NUM_CH-1:0]            ovf_pulse;
    logic [NUM_CH-1:0]            udf_pulse;
    logic [2*NUM_CH-1:0]          Cks;
    logic [NUM_CH-1:0]            Load_Tdr;
    logic [NUM_CH*DATA_WIDTH-1:0] count_start_value;
    logic [NUM_CH-1:0]            count_up_down;
    logic [NUM_CH-1:0]            count_enable;
    logic [NUM_CH-1:0]            oneshot_done;

    modport master (
        output TDR_reg, TCR_reg, TDR_WR_pulse, ovf_pulse, udf_pulse,
        input  Cks, Load_Tdr, count_start_value, count_up_down,
               count_enable, oneshot_done
    );

    modport slave (
        input  TDR_reg, TCR_reg, TDR_WR_pulse, ovf_pulse, udf_pulse,
        output Cks, Load_Tdr, count_start_value, count_up_down,
               count_enable, oneshot_done
    );
endinterface

// File: rtl/timer_ctrl_mc.sv
// -----------------------------------------------------------------------------
// timer_ctrl_mc
// Per-channel control for the timer subsystem: generates load strobes and
// start values (TDR write, TCR LOAD rising edge, auto-reload on terminal
// count), passes clock select / direction through, and runs a one-shot
// capable run-state FSM that gates the counter enable.
// Ports:
//   PCLK      in  system clock
//   PRESET_n  in  asynchronous active-low reset
//   bus       timer_ctrl_mc_if.slave (register images, strobes, controls)
// TCR map per channel: [1:0] CKS, [3] OS, [4] EN, [5] UP_DW, [6] ARE, [7] LOAD.
// -----------------------------------------------------------------------------
module timer_ctrl_mc #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 4
) (
    input  logic           PCLK,
    input  logic           PRESET_n,
    timer_ctrl_mc_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    logic [2*NUM_CH-1:0]          w_cks;
    logic [NUM_CH-1:0]            w_load;
    logic [NUM_CH*DATA_WIDTH-1:0] w_start;
    logic [NUM_CH-1:0]            w_up_dw;
    logic [NUM_CH-1:0]            w_cnt_en;
    logic [NUM_CH-1:0]            w_os_done;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [DATA_WIDTH-1:0] w_tcr;
        logic [DATA_WIDTH-1:0] w_tdr;
        logic                  w_os, w_en, w_up, w_are, w_ld;
        logic                  w_unused_tcr;
        logic                  w_edge, w_term;
        logic                  w_cnt_en_nxt, w_done_nxt;
        state_t                r_state, w_state_nxt;
        logic                  r_load_q, r_load_qq;
        logic                  r_load;
        logic [DATA_WIDTH-1:0] r_start;
        logic                  r_cnt_en, r_os_done;

        assign w_tcr = bus.TCR_reg[g*DATA_WIDTH +: DATA_WIDTH];
        assign w_tdr = bus.TDR_reg[g*DATA_WIDTH +: DATA_WIDTH];
        assign w_os  = w_tcr[3];
        assign w_en  = w_tcr[4];
        assign w_up  = w_tcr[5];
        assign w_are = w_tcr[6];
        assign w_ld  = w_tcr[7];
        // Reserved TCR bits are intentionally ignored.
        assign w_unused_tcr = ^w_tcr;

        assign w_edge = r_load_q & ~r_load_qq;
        // Only the wrap matching the current direction terminates a run.
        assign w_term = (r_state == ST_RUN) &
                        (w_up ? bus.ovf_pulse[g] : bus.udf_pulse[g]);

        // State register plus the registered Moore/Mealy outputs.
        always_ff @(posedge PCLK or negedge PRESET_n) begin
            if (!PRESET_n) begin
                r_state   <= ST_IDLE;
                r_cnt_en  <= 1'b0;
                r_os_done <= 1'b0;
            end else begin
                r_state   <= w_state_nxt;
                r_cnt_en  <= w_cnt_en_nxt;
                r_os_done <= w_done_nxt;
            end
        end

        // Next state: clearing EN takes precedence over a one-shot term.
        always_comb begin
            w_state_nxt = r_state;
            case (r_state)
                ST_IDLE: if (w_en) w_state_nxt = ST_RUN;
                ST_RUN: begin
                    if (!w_en)               w_state_nxt = ST_IDLE;
                    else if (w_term && w_os) w_state_nxt = ST_DONE;
                end
                ST_DONE: if (!w_en) w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end

        // Output decode, computed from the next state so the registered
        // enable tracks the state register cycle-for-cycle.
        always_comb begin
            w_cnt_en_nxt = (w_state_nxt == ST_RUN);
            w_done_nxt   = (r_state == ST_RUN) & w_en & w_term & w_os;
        end

        // Load path: all sources load TDR; priority only picks one strobe.
        always_ff @(posedge PCLK or negedge PRESET_n) begin
            if (!PRESET_n) begin
                r_load_q  <= 1'b0;
                r_load_qq <= 1'b0;
                r_load    <= 1'b0;
                r_start   <= '0;
            end else begin
                r_load_q  <= w_ld;
                r_load_qq <= r_load_q;
                r_load    <= 1'b0;
                if (bus.TDR_WR_pulse[g]) begin
                    r_load  <= 1'b1;
                    r_start <= w_tdr;
                end else if (w_edge) begin
                    r_load  <= 1'b1;
                    r_start <= w_tdr;
                end else if (w_term && w_are && !w_os) begin
                    r_load  <= 1'b1;
                    r_start <= w_tdr;
                end
            end
        end

        assign w_cks[g*2 +: 2]                 = w_tcr[1:0];
        assign w_up_dw[g]                      = w_up;
        assign w_load[g]                       = r_load;
        assign w_start[g*DATA_WIDTH +: DATA_WIDTH] = r_start;
        assign w_cnt_en[g]                     = r_cnt_en;
        assign w_os_done[g]                    = r_os_done;
    end

    assign bus.Cks               = w_cks;
    assign bus.count_up_down     = w_up_dw;
    assign bus.Load_Tdr          = w_load;
    assign bus.count_start_value = w_start;
    assign bus.count_enable      = w_cnt_en;
    assign bus.oneshot_done      = w_os_done;

endmodule

// File: tb/tb_timer_ctrl_mc.sv
// -----------------------------------------------------------------------------
// tb_timer_ctrl_mc
// Directed bench for timer_ctrl_mc (DATA_WIDTH=8, NUM_CH=4).
// Inputs change 1 time unit after a rising edge; outputs sampled there too.
// -----------------------------------------------------------------------------
module tb_timer_ctrl_mc;

    logic PCLK = 1'b0;
    logic PRESET_n;
    int   total = 0;
    int   bad   = 0;
    int   npulse;
    int   first;

    always #5 PCLK = ~PCLK;

    timer_ctrl_mc_if #(.DATA_WIDTH(8), .NUM_CH(4)) bus ();

    timer_ctrl_mc #(.DATA_WIDTH(8), .NUM_CH(4)) dut (
        .PCLK     (PCLK),
        .PRESET_n (PRESET_n),
        .bus      (bus.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic set_tcr(input int ch, input logic [7:0] v);
        bus.TCR_reg[ch*8 +: 8] = v;
    endtask

    task automatic set_tdr(input int ch, input logic [7:0] v);
        bus.TDR_reg[ch*8 +: 8] = v;
    endtask

    function automatic logic [7:0] csv(input int ch);
        return bus.count_start_value[ch*8 +: 8];
    endfunction

    initial begin
        PRESET_n         = 1'b0;
        bus.TDR_reg      = '0;
        bus.TCR_reg      = '0;
        bus.TDR_WR_pulse = '0;
        bus.ovf_pulse    = '0;
        bus.udf_pulse    = '0;
        #1;
        chk("rst_load",   64'(bus.Load_Tdr), 64'h0);
        chk("rst_en",     64'(bus.count_enable), 64'h0);
        chk("rst_done",   64'(bus.oneshot_done), 64'h0);
        chk("rst_start",  64'(bus.count_start_value), 64'h0);
        chk("rst_cks",    64'(bus.Cks), 64'h0);
        chk("rst_updown", 64'(bus.count_up_down), 64'h0);
        #11 PRESET_n = 1'b1;
        step();
        chk("idle_en", 64'(bus.count_enable), 64'h0);

        // ch0 enable: one cycle latency
        set_tcr(0, 8'h10);
        #1 chk("en_before_edge", 64'(bus.count_enable), 64'h0);
        step();
        chk("en_ch0", 64'(bus.count_enable), 64'h1);

        // ch1 TDR write
        set_tdr(1, 8'hA5);
        bus.TDR_WR_pulse = 4'b0010;
        step();
        chk("wr_load", 64'(bus.Load_Tdr), 64'h2);
        chk("wr_val",  64'(csv(1)), 64'hA5);
        bus.TDR_WR_pulse = '0;
        step();
        chk("wr_load_end", 64'(bus.Load_Tdr), 64'h0);
        chk("wr_val_hold", 64'(csv(1)), 64'hA5);

        // ch2 LOAD held high 10 cycles, CKS=3
        set_tdr(2, 8'h3C);
        set_tcr(2, 8'h83);
        #1 chk("cks_pass", 64'(bus.Cks), 64'h30);
        npulse = 0;
        first  = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (bus.Load_Tdr[2]) begin
                npulse++;
                if (first == 0) first = i;
            end
        end
        chk("ld_count", 64'(npulse), 64'd1);
        chk("ld_delay", 64'(first), 64'd2);
        chk("ld_val",   64'(csv(2)), 64'h3C);
        set_tcr(2, 8'h00);
        step();

        // ch0 up, ARE, auto-reload on ovf; udf ignored
        set_tdr(0, 8'hF0);
        set_tcr(0, 8'h70);
        #1 chk("updown_pass", 64'(bus.count_up_down), 64'h1);
        bus.ovf_pulse = 4'b0001;
        step();
        chk("are_load", 64'(bus.Load_Tdr), 64'h1);
        chk("are_val",  64'(csv(0)), 64'hF0);
        bus.ovf_pulse = '0;
        step();
        chk("are_load_end", 64'(bus.Load_Tdr), 64'h0);
        bus.udf_pulse = 4'b0001;
        step();
        chk("wrong_dir", 64'(bus.Load_Tdr), 64'h0);
        bus.udf_pulse = '0;

        // ch3 one-shot with ARE, down mode
        set_tdr(3, 8'h77);
        set_tcr(3, 8'h58);
        step();
        chk("os_run", 64'(bus.count_enable), 64'h9);
        bus.udf_pulse = 4'b1000;
        step();
        chk("os_en_off", 64'(bus.count_enable), 64'h1);
        chk("os_done",   64'(bus.oneshot_done), 64'h8);
        chk("os_noload", 64'(bus.Load_Tdr), 64'h0);
        bus.udf_pulse = '0;
        step();
        chk("os_done_end", 64'(bus.oneshot_done), 64'h0);
        bus.udf_pulse = 4'b1000;
        step();
        chk("os_ign_done", 64'(bus.oneshot_done), 64'h0);
        chk("os_ign_load", 64'(bus.Load_Tdr), 64'h0);
        chk("os_ign_en",   64'(bus.count_enable), 64'h1);
        bus.udf_pulse = '0;
        set_tcr(3, 8'h48);
        step();
        set_tcr(3, 8'h58);
        step();
        chk("os_rearm", 64'(bus.count_enable), 64'h9);
        chk("os_val0",  64'(csv(3)), 64'h00);

        // TDR write coincident with one-shot term
        set_tdr(3, 8'h99);
        bus.TDR_WR_pulse = 4'b1000;
        bus.udf_pulse    = 4'b1000;
        step();
        chk("co_load", 64'(bus.Load_Tdr), 64'h8);
        chk("co_done", 64'(bus.oneshot_done), 64'h8);
        chk("co_en",   64'(bus.count_enable), 64'h1);
        chk("co_val",  64'(csv(3)), 64'h99);
        bus.TDR_WR_pulse = '0;
        bus.udf_pulse    = '0;
        set_tcr(3, 8'h48);
        step();
        set_tcr(3, 8'h58);
        step();
        chk("co_rearm", 64'(bus.count_enable), 64'h9);

        // term while EN cleared: no done
        set_tcr(3, 8'h48);
        bus.udf_pulse = 4'b1000;
        step();
        chk("enclr_done", 64'(bus.oneshot_done), 64'h0);
        chk("enclr_en",   64'(bus.count_enable), 64'h1);
        bus.udf_pulse = '0;

        // ch0 simultaneous TDR write, LOAD edge, term
        set_tcr(0, 8'hF0);
        step();
        chk("sim_pre", 64'(bus.Load_Tdr), 64'h0);
        set_tdr(0, 8'h5A);
        bus.TDR_WR_pulse = 4'b0001;
        bus.ovf_pulse    = 4'b0001;
        step();
        chk("sim_load", 64'(bus.Load_Tdr), 64'h1);
        chk("sim_val",  64'(csv(0)), 64'h5A);
        bus.TDR_WR_pulse = '0;
        bus.ovf_pulse    = '0;
        step();
        chk("sim_single1", 64'(bus.Load_Tdr), 64'h0);
        step();
        chk("sim_single2", 64'(bus.Load_Tdr), 64'h0);

        // asynchronous reset mid-run
        chk("pre_rst_en", 64'(bus.count_enable), 64'h1);
        #2 PRESET_n = 1'b0;
        #1;
        chk("arst_en",    64'(bus.count_enable), 64'h0);
        chk("arst_start", 64'(bus.count_start_value), 64'h0);
        chk("arst_load",  64'(bus.Load_Tdr), 64'h0);
        set_tcr(0, 8'h70);
        #3 PRESET_n = 1'b1;
        step();
        chk("post_rst_en",   64'(bus.count_enable), 64'h1);
        chk("post_rst_load", 64'(bus.Load_Tdr), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
